// File: rtl/metrics_pkg.sv
// Shared definitions for the metrics display: metric and state encodings,
// segment constants, paging limits, conversion widths and small helpers.
package metrics_pkg;

  // Binary operand width and BCD accumulator geometry.
  localparam int CONV_W     = 35;
  localparam int BCD_DIGITS = 11;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  // Active-low segment patterns {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Highest page index per metric: 6 digits for 17-bit values, 12 for DIST.
  localparam logic [2:0] LAST_PAGE_SHORT = 3'd2;
  localparam logic [2:0] LAST_PAGE_DIST  = 3'd5;

  typedef enum logic [1:0] {
    AREA  = 2'd0,
    PERIM = 2'd1,
    DIST  = 2'd2
  } metric_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CONV = 2'd2,
    SHOW = 2'd3
  } state_e;

  // Decimal digit to active-low segment pattern; non-decimal codes blank.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction: every digit >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [2:0] last_page(input metric_e m);
    return (m == DIST) ? LAST_PAGE_DIST : LAST_PAGE_SHORT;
  endfunction

  // Paging order AREA -> PERIM -> DIST -> AREA.
  function automatic metric_e next_metric(input metric_e m);
    metric_e n;
    case (m)
      AREA:    n = PERIM;
      PERIM:   n = DIST;
      default: n = AREA;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/metrics_display_if.sv
// Bundle between the image-processing producer and the metrics display:
// metric inputs with their done strobe, and the display/status outputs.
interface metrics_display_if;
  logic        pdi_done;
  logic [16:0] hand_area;
  logic [16:0] hand_perimeter;
  logic [34:0] max_distance;
  logic [6:0]  hex1;
  logic [6:0]  hex0;
  logic [1:0]  metric_sel;
  logic [2:0]  page;
  logic        busy;
  logic        valid;

  // Producer side: drives metrics, observes the display.
  modport master (
    output pdi_done, hand_area, hand_perimeter, max_distance,
    input  hex1, hex0, metric_sel, page, busy, valid
  );

  // Display side.
  modport slave (
    input  pdi_done, hand_area, hand_perimeter, max_distance,
    output hex1, hex0, metric_sel, page, busy, valid
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one load cycle, then CONV_W
// add-3/shift iterations. done pulses for one cycle when bcd is final;
// start always reloads, which aborts a conversion in progress.
module bin2bcd_seq
  import metrics_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CONV_W-1:0] bin,
  output logic [BCD_W-1:0]  bcd,
  output logic              done
);

  localparam logic [5:0] ITER_LAST = 6'(CONV_W - 1);

  logic [CONV_W-1:0] shreg;
  logic [BCD_W-1:0]  adj;
  logic [5:0]        iter;
  logic              running;

  // Correction of the accumulator ahead of this cycle's shift.
  assign adj = bcd_adjust(bcd);

  // Load on start, otherwise shift {bcd, shreg} left once per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bcd     <= '0;
      iter    <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values and the shift pair updates as one.
      shreg   <= bin;
      bcd     <= '0;
      iter    <= '0;
      running <= 1'b1;
      done    <= 1'b0;
    end else if (running) begin
      bcd   <= {adj[BCD_W-2:0], shreg[CONV_W-1]};
      shreg <= {shreg[CONV_W-2:0], 1'b0};
      iter  <= iter + 6'd1;
      if (iter == ITER_LAST) begin
        running <= 1'b0;
        done    <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/metrics_display.sv
// Metrics display top: latches area/perimeter/distance on pdi_done, converts
// the selected metric to decimal and pages it two digits at a time onto two
// active-low 7-segment displays, cycling AREA -> PERIM -> DIST.
// Build option: define METRICS_DISPLAY_LZB_EN for leading-zero blanking.
module metrics_display
  import metrics_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int TMR_W        = 26
) (
  input logic               clk,
  input logic               rst,
  metrics_display_if.slave  bus
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DWELL_CYCLES - 1);

  state_e            state, state_next;
  metric_e           metric_sel, sel_next;
  logic [2:0]        page, page_next;
  logic [TMR_W-1:0]  tmr, tmr_next;
  logic [BCD_W-1:0]  disp, disp_next;
  logic              latch, hex_load;

  logic [16:0]       area_q, perim_q;
  logic [34:0]       dist_q;
  logic              valid_q;
  logic [6:0]        hex1_q, hex0_q;

  logic              conv_start, conv_done;
  logic [CONV_W-1:0] operand;
  logic [BCD_W-1:0]  bcd;

  logic [BCD_W+3:0]  ext;
  logic [3:0]        dig_hi, dig_lo;
  logic              blank_hi, blank_lo;
  logic [6:0]        seg_hi, seg_lo;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (operand),
    .bcd   (bcd),
    .done  (conv_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state plus next paging/timer/display values; pdi_done wins over all.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_next = state;
    sel_next   = metric_sel;
    page_next  = page;
    tmr_next   = tmr;
    disp_next  = disp;
    latch      = 1'b0;
    hex_load   = 1'b0;
    if (bus.pdi_done) begin
      latch      = 1'b1;
      sel_next   = AREA;
      page_next  = 3'd0;
      state_next = LOAD;
    end else begin
      case (state)
        LOAD: state_next = CONV;
        CONV: begin
          if (conv_done) begin
            disp_next  = bcd;
            page_next  = 3'd0;
            tmr_next   = '0;
            hex_load   = 1'b1;
            state_next = SHOW;
          end
        end
        SHOW: begin
          if (tmr == TMR_LAST) begin
            tmr_next = '0;
            if (page == last_page(metric_sel)) begin
              page_next  = 3'd0;
              sel_next   = next_metric(metric_sel);
              state_next = LOAD;
            end else begin
              page_next = page + 3'd1;
              hex_load  = 1'b1;
            end
          end else begin
            tmr_next = tmr + 1'b1;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  // Outputs: converter control, operand select and segment decode of the
  // page about to be shown.
  always_comb begin
    conv_start = (state == LOAD);
    case (metric_sel)
      AREA:    operand = CONV_W'(area_q);
      PERIM:   operand = CONV_W'(perim_q);
      DIST:    operand = dist_q;
      default: operand = '0;
    endcase
    // Digit 11 does not exist in the accumulator and always reads as 0.
    ext      = {4'h0, disp_next};
    dig_hi   = 4'h0;
    dig_lo   = 4'h0;
    blank_hi = 1'b0;
    blank_lo = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (page_next == 3'(i)) begin
        dig_hi = ext[8*i+4 +: 4];
        dig_lo = ext[8*i +: 4];
`ifdef METRICS_DISPLAY_LZB_EN
        // A digit blanks when it and every digit above it are zero.
        blank_hi = ((ext >> (8*i + 4)) == '0);
        blank_lo = (i != 0) && ((ext >> (8*i)) == '0);
`endif
      end
    end
    seg_hi = blank_hi ? SEG_BLANK : seg_of(dig_hi);
    seg_lo = blank_lo ? SEG_BLANK : seg_of(dig_lo);
  end

  // Datapath: shadow metrics, paging counters and the held hex pattern.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      metric_sel <= AREA;
      page       <= 3'd0;
      tmr        <= '0;
      disp       <= '0;
      area_q     <= '0;
      perim_q    <= '0;
      dist_q     <= '0;
      valid_q    <= 1'b0;
      hex1_q     <= SEG_DASH;
      hex0_q     <= SEG_DASH;
    end else begin
      metric_sel <= sel_next;
      page       <= page_next;
      tmr        <= tmr_next;
      disp       <= disp_next;
      if (latch) begin
        area_q  <= bus.hand_area;
        perim_q <= bus.hand_perimeter;
        dist_q  <= bus.max_distance;
        valid_q <= 1'b1;
      end
      // Hex only changes when a page is entered; LOAD/CONV keep the old one.
      if (hex_load) begin
        hex1_q <= seg_hi;
        hex0_q <= seg_lo;
      end
    end
  end

  assign bus.hex1       = hex1_q;
  assign bus.hex0       = hex0_q;
  assign bus.metric_sel = metric_sel;
  assign bus.page       = page;
  assign bus.busy       = (state == LOAD) || (state == CONV);
  assign bus.valid      = valid_q;

endmodule

// File: tb/tb_metrics_display.sv
// Directed bench for metrics_display with an 8-cycle dwell. Expected segment
// codes are hand-derived; leading-zero digits follow the LZB build option.
module tb_metrics_display;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  metrics_display_if bus ();

  metrics_display #(
    .DWELL_CYCLES (8),
    .TMR_W        (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [6:0] DASH = 7'h3F;
  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30,
                         S4 = 7'h19, S5 = 7'h12, S6 = 7'h02, S7 = 7'h78,
                         S8 = 7'h00, S9 = 7'h10;
`ifdef METRICS_DISPLAY_LZB_EN
  localparam logic [6:0] ZL = 7'h7F;
`else
  localparam logic [6:0] ZL = 7'h40;
`endif
  localparam logic [34:0] DMAX = 35'h7FFFFFFFF;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_hex(input string tag, input logic [6:0] hi, input logic [6:0] lo);
    check({tag, ".hex1"}, 16'(bus.hex1), 16'(hi));
    check({tag, ".hex0"}, 16'(bus.hex0), 16'(lo));
  endtask

  task automatic check_pos(input string tag, input logic [1:0] sel, input logic [2:0] pg,
                           input logic bsy);
    check({tag, ".sel"},  16'(bus.metric_sel), 16'(sel));
    check({tag, ".page"}, 16'(bus.page), 16'(pg));
    check({tag, ".busy"}, 16'(bus.busy), 16'(bsy));
  endtask

  // Called at a negedge; pdi_done is sampled on the following posedge.
  task automatic pulse(input logic [16:0] a, input logic [16:0] p, input logic [34:0] d);
    bus.hand_area      = a;
    bus.hand_perimeter = p;
    bus.max_distance   = d;
    bus.pdi_done       = 1'b1;
    @(negedge clk);
    bus.pdi_done       = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                = 1'b0;
    bus.pdi_done       = 1'b0;
    bus.hand_area      = '0;
    bus.hand_perimeter = '0;
    bus.max_distance   = '0;
    #12;
    check_hex("rst", DASH, DASH);
    @(negedge clk);
    rst = 1'b1;
    cycles(100);
    check_hex("idle", DASH, DASH);
    check_pos("idle", 2'd0, 3'd0, 1'b0);
    check("idle.valid", 16'(bus.valid), 16'd0);

    // Full paging pass: 12345 / 678 / 34359738367.
    pulse(17'd12345, 17'd678, DMAX);
    check_pos("load", 2'd0, 3'd0, 1'b1);
    check("load.valid", 16'(bus.valid), 16'd1);
    check_hex("load", DASH, DASH);
    cycles(36);
    check_hex("lat36", DASH, DASH);
    cycles(1);
    check_hex("area.p0", S4, S5);
    check_pos("area.p0", 2'd0, 3'd0, 1'b0);
    cycles(8);
    check_hex("area.p1", S2, S3);
    cycles(8);
    check_hex("area.p2", ZL, S1);
    cycles(8);
    check_pos("perim.load", 2'd1, 3'd0, 1'b1);
    check_hex("perim.hold", ZL, S1);
    cycles(37);
    check_hex("perim.p0", S7, S8);
    cycles(8);
    check_hex("perim.p1", ZL, S6);
    cycles(8);
    check_hex("perim.p2", ZL, ZL);
    cycles(8);
    check_pos("dist.load", 2'd2, 3'd0, 1'b1);
    cycles(37);
    check_hex("dist.p0", S6, S7);
    cycles(8);
    check_hex("dist.p1", S8, S3);
    cycles(8);
    check_hex("dist.p2", S7, S3);
    cycles(8);
    check_hex("dist.p3", S5, S9);
    cycles(8);
    check_hex("dist.p4", S4, S3);
    cycles(8);
    check_hex("dist.p5", ZL, S3);
    check_pos("dist.p5", 2'd2, 3'd5, 1'b0);
    cycles(8);
    check_pos("wrap", 2'd0, 3'd0, 1'b1);
    cycles(37);
    check_hex("wrap.p0", S4, S5);

    // Abort during DIST page 3 of the next pass.
    cycles(146);
    check_pos("dist2.p3", 2'd2, 3'd3, 1'b0);
    check_hex("dist2.p3", S5, S9);
    pulse(17'd99, 17'd678, DMAX);
    check_pos("abort", 2'd0, 3'd0, 1'b1);
    check_hex("abort.hold", S5, S9);
    cycles(37);
    check_hex("abort.p0", S9, S9);
    check_pos("abort.p0", 2'd0, 3'd0, 1'b0);

    // Asynchronous reset mid-conversion.
    pulse(17'd12345, 17'd678, DMAX);
    cycles(10);
    #2 rst = 1'b0;
    #1;
    check_hex("arst", DASH, DASH);
    check_pos("arst", 2'd0, 3'd0, 1'b0);
    check("arst.valid", 16'(bus.valid), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    cycles(50);
    check_hex("arst.idle", DASH, DASH);
    check_pos("arst.idle", 2'd0, 3'd0, 1'b0);

    // Zero value, then pdi_done on the very dwell-expiry edge of the last page.
    pulse(17'd0, 17'd678, 35'd5);
    cycles(37);
    check_hex("zero.p0", ZL, S0);
    cycles(23);
    check_pos("zero.p2", 2'd0, 3'd2, 1'b0);
    pulse(17'd12345, 17'd678, DMAX);
    check_pos("prio", 2'd0, 3'd0, 1'b1);
    check_hex("prio.hold", ZL, ZL);
    cycles(37);
    check_hex("prio.p0", S4, S5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
